fpga_cfg_loader: RTL and testbench

Configuration loader that sits directly upstream of the fpga fabric. It receives a byte-wide bitstream over a valid/ready handshake and hunts for a sync word. It collects the payload into a shadow register and checks an XOR checksum. On success it atomically commits the payload to the flattened configuration buses that drive the logic-tile LUT/FF-select memories (33 bits each) and the 4x4 switch-box crossbars (16 bits each).

---
 rtl/fpga_cfg_pkg.sv | 26 ++
 rtl/fpga_cfg_loader_if.sv | 9 +
 rtl/cfg_shadow_sr.sv | 41 ++++
 rtl/fpga_cfg_loader.sv | 185 ++++++++++++++++++
 tb/tb_fpga_cfg_loader.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared defaults, derived sizes and state encoding for the FPGA configuration loader.
package fpga_cfg_pkg;

  localparam int N_TILES_DEF   = 8;
  localparam int TILE_BITS_DEF = 33;
  localparam int N_SB_DEF      = 5;
  localparam int SB_BITS_DEF   = 16;
  localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;

  localparam int CFG_BITS_DEF      = N_TILES_DEF * TILE_BITS_DEF + N_SB_DEF * SB_BITS_DEF;
  localparam int PAYLOAD_BYTES_DEF = (CFG_BITS_DEF + 7) / 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HUNT   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  // Running frame checksum: plain XOR of every payload byte, pad bits included.
  function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] data);
    return chk ^ data;
  endfunction

endpackage

// File: rtl/fpga_cfg_loader_if.sv
// Byte-wide valid/ready bitstream channel feeding the configuration loader.
interface fpga_cfg_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/cfg_shadow_sr.sv
// Byte-shift shadow register for the incoming payload plus its running XOR checksum.
module cfg_shadow_sr
  import fpga_cfg_pkg::*;
#(
  parameter int PAYLOAD_BYTES = PAYLOAD_BYTES_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       shift_en,
  input  logic [7:0]                 byte_in,
  output logic [PAYLOAD_BYTES*8-1:0] shadow,
  output logic [7:0]                 chk
);

  localparam int W = PAYLOAD_BYTES * 8;

  logic [W-1:0] shadow_r;
  logic [7:0]   chk_r;

  // New bytes enter at the top so the first payload byte ends up in bits [7:0].
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_r <= '0;
      chk_r    <= 8'h00;
    end else if (clear) begin
      shadow_r <= '0;
      chk_r    <= 8'h00;
    end else if (shift_en) begin
      shadow_r <= {byte_in, shadow_r[W-1:8]};
      chk_r    <= chk_update(chk_r, byte_in);
    end else begin
      shadow_r <= shadow_r;
      chk_r    <= chk_r;
    end
  end

  assign shadow = shadow_r;
  assign chk    = chk_r;

endmodule

// File: rtl/fpga_cfg_loader.sv
// Sync-hunting bitstream loader that checks an XOR checksum and atomically
// commits the payload to the tile and switch-box configuration buses.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int         N_TILES   = N_TILES_DEF,
  parameter int         TILE_BITS = TILE_BITS_DEF,
  parameter int         N_SB      = N_SB_DEF,
  parameter int         SB_BITS   = SB_BITS_DEF,
  parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  fpga_cfg_loader_if.slave             bs,
  output logic [N_TILES*TILE_BITS-1:0] tile_cfg,
  output logic [N_SB*SB_BITS-1:0]      sb_cfg,
  output logic                         busy,
  output logic                         cfg_done,
  output logic                         cfg_error
);

  localparam int TILE_W        = N_TILES * TILE_BITS;
  localparam int SB_W          = N_SB * SB_BITS;
  localparam int CFG_BITS      = TILE_W + SB_W;
  localparam int PAYLOAD_BYTES = (CFG_BITS + 7) / 8;
  localparam int CNT_BITS      = $clog2(PAYLOAD_BYTES + 1);
  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(PAYLOAD_BYTES - 1);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_HUNT   = ST_HUNT;
  localparam logic [2:0] S_LOAD   = ST_LOAD;
  localparam logic [2:0] S_CHECK  = ST_CHECK;
  localparam logic [2:0] S_COMMIT = ST_COMMIT;

  logic [2:0]                 state_r;
  logic [2:0]                 fsm_next_s;
  logic [2:0]                 state_n_s;
  logic [CNT_BITS-1:0]        count_r;
  logic                       in_ready_r;
  logic                       busy_r;
  logic                       cfg_done_r;
  logic                       cfg_error_r;
  logic [TILE_W-1:0]          tile_cfg_r;
  logic [SB_W-1:0]            sb_cfg_r;
  logic [PAYLOAD_BYTES*8-1:0] shadow_s;
  logic [7:0]                 chk_s;
  logic                       xfer_s;
  logic                       shadow_clr_s;
  logic                       shift_s;
  logic                       commit_s;
  logic                       err_set_s;
  logic                       flags_clr_s;
  logic                       commit_en_s;
  logic                       err_en_s;
  logic                       flags_clr_en_s;

  assign xfer_s = bs.in_valid && in_ready_r;

  // Frame-level control; abort is folded in afterwards so it overrides everything.
  always_comb begin
    fsm_next_s   = state_r;
    shadow_clr_s = 1'b0;
    shift_s      = 1'b0;
    commit_s     = 1'b0;
    err_set_s    = 1'b0;
    flags_clr_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          flags_clr_s = 1'b1;
          fsm_next_s  = S_HUNT;
        end else begin
          fsm_next_s = S_IDLE;
        end
      end
      S_HUNT: begin
        if (xfer_s && (bs.in_data == SYNC_WORD)) begin
          shadow_clr_s = 1'b1;
          fsm_next_s   = S_LOAD;
        end else begin
          fsm_next_s = S_HUNT;
        end
      end
      S_LOAD: begin
        if (xfer_s) begin
          shift_s = 1'b1;
          if (count_r == LAST_IDX) begin
            fsm_next_s = S_CHECK;
          end else begin
            fsm_next_s = S_LOAD;
          end
        end else begin
          fsm_next_s = S_LOAD;
        end
      end
      S_CHECK: begin
        if (xfer_s) begin
          if (bs.in_data == chk_s) begin
            fsm_next_s = S_COMMIT;
          end else begin
            err_set_s  = 1'b1;
            fsm_next_s = S_IDLE;
          end
        end else begin
          fsm_next_s = S_CHECK;
        end
      end
      S_COMMIT: begin
        commit_s   = 1'b1;
        fsm_next_s = S_IDLE;
      end
      default: begin
        fsm_next_s = S_IDLE;
      end
    endcase
  end

  assign state_n_s      = abort ? S_IDLE : fsm_next_s;
  assign commit_en_s    = commit_s && !abort;
  assign err_en_s       = err_set_s && !abort;
  assign flags_clr_en_s = flags_clr_s && !abort;

  // State, handshake/status outputs, byte counter and the committed configuration.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= S_IDLE;
      count_r     <= '0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      cfg_done_r  <= 1'b0;
      cfg_error_r <= 1'b0;
      tile_cfg_r  <= '0;
      sb_cfg_r    <= '0;
    end else begin
      state_r    <= state_n_s;
      in_ready_r <= (state_n_s == S_HUNT) || (state_n_s == S_LOAD) || (state_n_s == S_CHECK);
      busy_r     <= (state_n_s != S_IDLE);
      if (shadow_clr_s) begin
        count_r <= '0;
      end else if (shift_s) begin
        count_r <= count_r + CNT_BITS'(1);
      end else begin
        count_r <= count_r;
      end
      if (commit_en_s) begin
        tile_cfg_r <= shadow_s[TILE_W-1:0];
        sb_cfg_r   <= shadow_s[CFG_BITS-1:TILE_W];
        cfg_done_r <= 1'b1;
      end else if (flags_clr_en_s) begin
        cfg_done_r <= 1'b0;
      end else begin
        cfg_done_r <= cfg_done_r;
      end
      if (err_en_s) begin
        cfg_error_r <= 1'b1;
      end else if (flags_clr_en_s) begin
        cfg_error_r <= 1'b0;
      end else begin
        cfg_error_r <= cfg_error_r;
      end
    end
  end

  cfg_shadow_sr #(
    .PAYLOAD_BYTES (PAYLOAD_BYTES)
  ) u_shadow (
    .clock    (clock),
    .reset    (reset),
    .clear    (shadow_clr_s),
    .shift_en (shift_s),
    .byte_in  (bs.in_data),
    .shadow   (shadow_s),
    .chk      (chk_s)
  );

  assign bs.in_ready = in_ready_r;
  assign busy        = busy_r;
  assign cfg_done    = cfg_done_r;
  assign cfg_error   = cfg_error_r;
  assign tile_cfg    = tile_cfg_r;
  assign sb_cfg      = sb_cfg_r;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Scoreboard bench: each load pushes its expected end state; a monitor compares
// the configuration and status whenever busy falls.
module tb_fpga_cfg_loader;

  localparam int TW = 264;
  localparam int SW = 80;
  localparam int PB = 43;

  localparam logic [TW-1:0] TILE_A = TW'(1) | (TW'(1) << 33);
  localparam logic [SW-1:0] SB_A   = SW'(1);
  localparam logic [TW-1:0] TILE_B = TW'(8'hF0);
  localparam logic [SW-1:0] SB_B   = SW'(1) << 79;
  localparam logic [TW-1:0] TILE_C = TW'(1) << 80;
  localparam logic [SW-1:0] SB_C   = SW'(1) << 57;

  typedef struct {
    logic [TW-1:0] tile;
    logic [SW-1:0] sb;
    logic          done;
    logic          err;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [TW-1:0] tile_cfg;
  logic [SW-1:0] sb_cfg;
  logic          busy;
  logic          cfg_done;
  logic          cfg_error;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] pay [PB];

  fpga_cfg_loader_if bs ();

  fpga_cfg_loader dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .bs        (bs.slave),
    .tile_cfg  (tile_cfg),
    .sb_cfg    (sb_cfg),
    .busy      (busy),
    .cfg_done  (cfg_done),
    .cfg_error (cfg_error)
  );

  always #5 clock = ~clock;

  function automatic void check1(input string name, input logic [TW-1:0] act, input logic [TW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  function automatic void push_exp(input logic [TW-1:0] t, input logic [SW-1:0] s, input logic d, input logic e);
    exp_t x;
    x.tile = t;
    x.sb   = s;
    x.done = d;
    x.err  = e;
    exp_q.push_back(x);
  endfunction

  // Monitor: compare end-of-load state against the scoreboard on each busy fall.
  initial begin : monitor
    exp_t x;
    logic busy_q;
    busy_q = 1'b0;
    forever begin
      @(negedge clock);
      if (busy_q === 1'b1 && busy === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got busy fall expected none");
        end else begin
          x = exp_q.pop_front();
          check1("sb_tile_cfg", tile_cfg, x.tile);
          check1("sb_sb_cfg", TW'(sb_cfg), TW'(x.sb));
          check1("sb_cfg_done", TW'(cfg_done), TW'(x.done));
          check1("sb_cfg_error", TW'(cfg_error), TW'(x.err));
        end
      end
      busy_q = busy;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_pay();
    for (int i = 0; i < PB; i++) pay[i] = 8'h00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Starts and ends on a falling edge; the transfer happens on the rising edge in between.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int tries;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clock);
    bs.in_data  = b;
    bs.in_valid = 1'b1;
    tries = 0;
    while (bs.in_ready !== 1'b1 && tries < 20) begin
      @(negedge clock);
      tries++;
    end
    if (tries >= 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got in_ready=%b expected 1", bs.in_ready);
    end
    @(negedge clock);
    bs.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] chk, input bit good, input bit gaps);
    send_byte(8'hA5, gaps);
    for (int i = 0; i < PB; i++) send_byte(pay[i], gaps);
    send_byte(chk, gaps);
    if (good) begin
      check1("commit_busy_hold", TW'(busy), TW'(1'b1));
      check1("commit_done_early", TW'(cfg_done), TW'(1'b0));
      @(negedge clock);
      check1("commit_busy_fall", TW'(busy), TW'(1'b0));
      check1("commit_done_set", TW'(cfg_done), TW'(1'b1));
    end else begin
      check1("badchk_busy", TW'(busy), TW'(1'b0));
      check1("badchk_error", TW'(cfg_error), TW'(1'b1));
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin : stimulus
    reset       = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    bs.in_data  = 8'h00;
    bs.in_valid = 1'b0;
    repeat (3) @(negedge clock);
    check1("rst_in_ready", TW'(bs.in_ready), TW'(1'b0));
    check1("rst_busy", TW'(busy), TW'(1'b0));
    check1("rst_done", TW'(cfg_done), TW'(1'b0));
    check1("rst_error", TW'(cfg_error), TW'(1'b0));
    check1("rst_tile", tile_cfg, TW'(0));
    check1("rst_sb", TW'(sb_cfg), TW'(0));
    reset = 1'b0;
    @(negedge clock);

    // Happy path
    clear_pay();
    pay[0] = 8'h01; pay[4] = 8'h02; pay[33] = 8'h01;
    push_exp(TILE_A, SB_A, 1'b1, 1'b0);
    pulse_start();
    send_frame(8'h02, 1'b1, 1'b0);

    // Bad checksum keeps the previous configuration
    push_exp(TILE_A, SB_A, 1'b0, 1'b1);
    pulse_start();
    send_frame(8'h03, 1'b0, 1'b0);

    // Junk before the sync word is discarded
    clear_pay();
    pay[0] = 8'hF0; pay[42] = 8'h80;
    push_exp(TILE_B, SB_B, 1'b1, 1'b0);
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h5A, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_frame(8'h70, 1'b1, 1'b0);

    // Random valid gaps through the whole frame
    clear_pay();
    pay[0] = 8'h01; pay[4] = 8'h02; pay[33] = 8'h01;
    push_exp(TILE_A, SB_A, 1'b1, 1'b0);
    pulse_start();
    send_frame(8'h02, 1'b1, 1'b1);

    // Abort part-way through LOAD, then a clean frame
    push_exp(TILE_A, SB_A, 1'b0, 1'b0);
    pulse_start();
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 20; i++) send_byte(8'hFF, 1'b0);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check1("abort_busy", TW'(busy), TW'(1'b0));
    check1("abort_in_ready", TW'(bs.in_ready), TW'(1'b0));
    repeat (2) @(negedge clock);
    clear_pay();
    pay[10] = 8'h01; pay[40] = 8'h02;
    push_exp(TILE_C, SB_C, 1'b1, 1'b0);
    pulse_start();
    send_frame(8'h03, 1'b1, 1'b0);

    // Reset during LOAD, with a simultaneous start that must be ignored
    push_exp(TW'(0), SW'(0), 1'b0, 1'b0);
    pulse_start();
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 10; i++) send_byte(8'h11, 1'b0);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    check1("midrst_in_ready", TW'(bs.in_ready), TW'(1'b0));
    check1("midrst_busy", TW'(busy), TW'(1'b0));
    check1("midrst_done", TW'(cfg_done), TW'(1'b0));
    check1("midrst_error", TW'(cfg_error), TW'(1'b0));
    check1("midrst_tile", tile_cfg, TW'(0));
    check1("midrst_sb", TW'(sb_cfg), TW'(0));
    @(negedge clock);
    check1("midrst_start_ignored", TW'(busy), TW'(1'b0));

    repeat (3) @(negedge clock);
    check1("sb_all_consumed", TW'(exp_q.size()), TW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
